// File: rtl/change_pkg.sv
// Shared coin codes, coin values and FSM state encoding for the change dispenser
// and the upstream change-box evaluator.
package change_pkg;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b101;

  localparam logic [3:0] VAL_NICKEL  = 4'd1;
  localparam logic [3:0] VAL_DIME    = 4'd2;
  localparam logic [3:0] VAL_QUARTER = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    SELECT,
    PRESENT,
    FINISH
  } state_t;

  function automatic logic [3:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_QUARTER: return VAL_QUARTER;
      COIN_DIME:    return VAL_DIME;
      COIN_NICKEL:  return VAL_NICKEL;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin choice: largest coin that still fits the amount owed and is in stock.
module coin_select
  import change_pkg::*;
(
  input  logic [3:0] remaining,
  input  logic [1:0] quarters,
  input  logic [1:0] dimes,
  input  logic [1:0] nickels,
  output logic [2:0] coin
);

  always_comb begin
    coin = COIN_NONE;
    if (remaining >= VAL_QUARTER && quarters != '0)
      coin = COIN_QUARTER;
    else if (remaining >= VAL_DIME && dimes != '0)
      coin = COIN_DIME;
    else if (remaining >= VAL_NICKEL && nickels != '0)
      coin = COIN_NICKEL;
  end

endmodule

// File: rtl/change_dispenser.sv
// Transaction FSM owning the coin inventory; pays change one coin at a time over
// a valid/ack handshake and reports the transaction outcome.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned MAX_COUNT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LoadInventory,
  input  logic [1:0] QuartersIn,
  input  logic [1:0] DimesIn,
  input  logic [1:0] NickelsIn,
  input  logic       Start,
  input  logic [3:0] Cost,
  input  logic [3:0] Paid,
  input  logic       CoinAck,
  output logic       CoinValid,
  output logic [2:0] CoinValue,
  output logic       Busy,
  output logic       Done,
  output logic       ExactAmount,
  output logic       CoughUpMore,
  output logic       NotEnoughChange,
  output logic       Fault,
  output logic [3:0] Remaining,
  output logic [1:0] Quarters,
  output logic [1:0] Dimes,
  output logic [1:0] Nickels
);

  localparam int unsigned TW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0]  MAXC = 2'(MAX_COUNT);

  state_t        state;
  logic [3:0]    cost_q;
  logic [3:0]    paid_q;
  logic [TW-1:0] tmo;
  logic [2:0]    sel_coin;

  function automatic logic [1:0] sat(input logic [1:0] v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  coin_select u_sel (
    .remaining (Remaining),
    .quarters  (Quarters),
    .dimes     (Dimes),
    .nickels   (Nickels),
    .coin      (sel_coin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cost_q          <= '0;
      paid_q          <= '0;
      tmo             <= '0;
      CoinValid       <= 1'b0;
      CoinValue       <= COIN_NONE;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      ExactAmount     <= 1'b0;
      CoughUpMore     <= 1'b0;
      NotEnoughChange <= 1'b0;
      Fault           <= 1'b0;
      Remaining       <= '0;
      Quarters        <= '0;
      Dimes           <= '0;
      Nickels         <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (LoadInventory) begin
            Quarters <= sat(QuartersIn);
            Dimes    <= sat(DimesIn);
            Nickels  <= sat(NickelsIn);
          end else if (Start) begin
            cost_q          <= Cost;
            paid_q          <= Paid;
            ExactAmount     <= 1'b0;
            CoughUpMore     <= 1'b0;
            NotEnoughChange <= 1'b0;
            Fault           <= 1'b0;
            Busy            <= 1'b1;
            state           <= EVAL;
          end
        end
        EVAL: begin
          if (paid_q < cost_q) begin
            CoughUpMore <= 1'b1;
            Remaining   <= '0;
            Done        <= 1'b1;
            state       <= FINISH;
          end else if (paid_q == cost_q) begin
            ExactAmount <= 1'b1;
            Remaining   <= '0;
            Done        <= 1'b1;
            state       <= FINISH;
          end else begin
            Remaining <= paid_q - cost_q;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (Remaining == '0) begin
            Done  <= 1'b1;
            state <= FINISH;
          end else if (sel_coin != COIN_NONE) begin
            CoinValid <= 1'b1;
            CoinValue <= sel_coin;
            tmo       <= '0;
            state     <= PRESENT;
          end else begin
            NotEnoughChange <= 1'b1;
            Done            <= 1'b1;
            state           <= FINISH;
          end
        end
        PRESENT: begin
          if (CoinAck) begin
            case (CoinValue)
              COIN_QUARTER: Quarters <= Quarters - 2'd1;
              COIN_DIME:    Dimes    <= Dimes - 2'd1;
              COIN_NICKEL:  Nickels  <= Nickels - 2'd1;
              default:      ;
            endcase
            Remaining <= Remaining - coin_value(CoinValue);
            CoinValid <= 1'b0;
            CoinValue <= COIN_NONE;
            tmo       <= '0;
            state     <= SELECT;
          end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
            // CoinValid has now been up ACK_TIMEOUT cycles without an ack
            Fault     <= 1'b1;
            CoinValid <= 1'b0;
            CoinValue <= COIN_NONE;
            tmo       <= '0;
            Done      <= 1'b1;
            state     <= FINISH;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FINISH: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
